rb_param: RTL and testbench

RB_PARAM -- requirements
Module: rb_param

---
 rtl/rb_param_pkg.sv | 24 ++
 rtl/rb_param_w1c_reg.sv | 43 ++++
 rtl/rb_param.sv | 160 ++++++++++++++++
 tb/tb_rb_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_param_pkg.sv
// rb_param shared package: default parameters, commit address
// derivation and the address-decode helper.
package rb_param_pkg;

    localparam int DEF_ADR_BITS  = 8;
    localparam int DEF_N_CFG     = 16;
    localparam int DEF_N_STAT    = 4;
    localparam int DEF_STAT_BASE = 32;

    // Commit register sits at the all-ones address.
    function automatic int commit_adr(input int adr_bits);
        return (1 << adr_bits) - 1;
    endfunction

    // True when adr selects register idx of the bank starting at base.
    function automatic logic adr_hit(
        input logic [31:0] adr,
        input int          base,
        input int          idx
    );
        return adr == 32'(base + idx);
    endfunction

endpackage

// File: rtl/rb_param_w1c_reg.sv
// One sticky status byte with write-1-to-clear, its mask register
// and the masked-OR interrupt contribution.
// Ports: i_clk, i_reset (sync, active high), i_set (per-bit set),
//   i_clr_we (W1C strobe), i_mask_we (mask write strobe), i_wdata,
//   o_status, o_mask, o_hit (|(status & mask)).
module rb_param_w1c_reg
    import rb_param_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_set,
    input  logic       i_clr_we,
    input  logic       i_mask_we,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_status,
    output logic [7:0] o_mask,
    output logic       o_hit
);

    logic [7:0] r_status;
    logic [7:0] r_mask;
    logic [7:0] w_clr;

    assign w_clr = i_clr_we ? i_wdata : 8'h00;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_status <= 8'h00;
            r_mask   <= 8'h00;
        end else begin
            if (i_mask_we) begin
                r_mask <= i_wdata;
            end
            // Set wins over a same-cycle clear.
            r_status <= (r_status & ~w_clr) | i_set;
        end
    end

    assign o_status = r_status;
    assign o_mask   = r_mask;
    assign o_hit    = |(r_status & r_mask);

endmodule

// File: rtl/rb_param.sv
// rb_param: parameterised register bank with config registers,
// sticky W1C status registers, masks and a registered interrupt.
// Optional shadow bank with commit: define RB_PARAM_SHADOW_EN.
// Ports: clk, reset (sync, active high), address, data_write_in,
//   write_en, reg_en (read request), data_read_out, read_valid
//   (one cycle after reg_en), cfg_out, cfg_wr_pulse, stat_set, irq.
module rb_param
    import rb_param_pkg::*;
#(
    parameter int                      ADR_BITS  = DEF_ADR_BITS,
    parameter int                      N_CFG     = DEF_N_CFG,
    parameter int                      N_STAT    = DEF_N_STAT,
    parameter int                      STAT_BASE = DEF_STAT_BASE,
    parameter logic [N_CFG*8-1:0]      CFG_RESET = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADR_BITS-1:0]        address,
    input  logic [7:0]                 data_write_in,
    input  logic                       write_en,
    input  logic                       reg_en,
    output logic [7:0]                 data_read_out,
    output logic                       read_valid,
    output logic [N_CFG*8-1:0]         cfg_out,
    output logic [N_CFG-1:0]           cfg_wr_pulse,
    input  logic [N_STAT*8-1:0]        stat_set,
    output logic                       irq
);

    localparam int MASK_BASE  = STAT_BASE + N_STAT;
    localparam int COMMIT_ADR = commit_adr(ADR_BITS);

    if (STAT_BASE < N_CFG || MASK_BASE + N_STAT > COMMIT_ADR) begin : g_bad_map
        $error("rb_param: overlapping register map");
    end

    logic [N_CFG*8-1:0]  r_cfg;
    logic [N_CFG-1:0]    r_pulse;
    logic [7:0]          r_rdata;
    logic                r_rvalid;
    logic                r_irq;

    logic [31:0]         w_adr;
    logic [N_CFG-1:0]    w_cfg_we;
    logic [N_CFG*8-1:0]  w_cfg_view;
    logic [N_STAT*8-1:0] w_stat;
    logic [N_STAT*8-1:0] w_mask;
    logic [N_STAT-1:0]   w_hit;
    logic [7:0]          w_rd;

    assign w_adr = 32'(address);

    always_comb begin
        w_cfg_we = '0;
        for (int i = 0; i < N_CFG; i++) begin
            w_cfg_we[i] = write_en && adr_hit(w_adr, 0, i);
        end
    end

    for (genvar k = 0; k < N_STAT; k++) begin : g_stat
        logic w_clr_we;
        logic w_mask_we;

        assign w_clr_we  = write_en && adr_hit(w_adr, STAT_BASE, k);
        assign w_mask_we = write_en && adr_hit(w_adr, MASK_BASE, k);

        rb_param_w1c_reg u_reg (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_set     (stat_set[k*8 +: 8]),
            .i_clr_we  (w_clr_we),
            .i_mask_we (w_mask_we),
            .i_wdata   (data_write_in),
            .o_status  (w_stat[k*8 +: 8]),
            .o_mask    (w_mask[k*8 +: 8]),
            .o_hit     (w_hit[k])
        );
    end

`ifdef RB_PARAM_SHADOW_EN
    logic [N_CFG*8-1:0] r_shadow;
    logic               w_commit;

    assign w_commit = write_en && data_write_in[0]
                   && adr_hit(w_adr, COMMIT_ADR, 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= CFG_RESET;
        end else begin
            for (int i = 0; i < N_CFG; i++) begin
                if (w_cfg_we[i]) begin
                    r_shadow[i*8 +: 8] <= data_write_in;
                end
            end
        end
    end

    // Software sees the pending (shadow) image.
    assign w_cfg_view = r_shadow;
`else
    assign w_cfg_view = r_cfg;
`endif

    // Read mux works on pre-edge state, so a same-cycle write
    // to the read address returns the old value.
    always_comb begin
        w_rd = 8'h00;
        for (int i = 0; i < N_CFG; i++) begin
            if (adr_hit(w_adr, 0, i)) begin
                w_rd = w_cfg_view[i*8 +: 8];
            end
        end
        for (int k = 0; k < N_STAT; k++) begin
            if (adr_hit(w_adr, STAT_BASE, k)) begin
                w_rd = w_stat[k*8 +: 8];
            end
            if (adr_hit(w_adr, MASK_BASE, k)) begin
                w_rd = w_mask[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg    <= CFG_RESET;
            r_pulse  <= '0;
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= reg_en;
            r_rdata  <= reg_en ? w_rd : 8'h00;
            r_irq    <= |w_hit;
            r_pulse  <= '0;
`ifdef RB_PARAM_SHADOW_EN
            if (w_commit) begin
                r_cfg <= r_shadow;
                for (int i = 0; i < N_CFG; i++) begin
                    r_pulse[i] <= r_shadow[i*8 +: 8] != r_cfg[i*8 +: 8];
                end
            end
`else
            for (int i = 0; i < N_CFG; i++) begin
                if (w_cfg_we[i]) begin
                    r_cfg[i*8 +: 8] <= data_write_in;
                    r_pulse[i]      <= 1'b1;
                end
            end
`endif
        end
    end

    assign cfg_out       = r_cfg;
    assign cfg_wr_pulse  = r_pulse;
    assign data_read_out = r_rdata;
    assign read_valid    = r_rvalid;
    assign irq           = r_irq;

endmodule

// File: tb/tb_rb_param.sv
// Testbench for rb_param: directed steps then randomized traffic,
// checked against an array-based model of the register map.
module tb_rb_param;

    localparam int NC = 16;
    localparam int NS = 4;
    localparam logic [NC*8-1:0] RST_IMG = {NC{8'hA5}};

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      address;
    logic [7:0]      data_write_in;
    logic            write_en;
    logic            reg_en;
    logic [7:0]      data_read_out;
    logic            read_valid;
    logic [NC*8-1:0] cfg_out;
    logic [NC-1:0]   cfg_wr_pulse;
    logic [NS*8-1:0] stat_set;
    logic            irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_cfg    [NC];
    logic [7:0] m_shadow [NC];
    logic [7:0] m_stat   [NS];
    logic [7:0] m_mask   [NS];

    always #5 clk = ~clk;

    rb_param #(
        .ADR_BITS  (8),
        .N_CFG     (NC),
        .N_STAT    (NS),
        .STAT_BASE (32),
        .CFG_RESET (RST_IMG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .data_write_in (data_write_in),
        .write_en      (write_en),
        .reg_en        (reg_en),
        .data_read_out (data_read_out),
        .read_valid    (read_valid),
        .cfg_out       (cfg_out),
        .cfg_wr_pulse  (cfg_wr_pulse),
        .stat_set      (stat_set),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a < NC) begin
`ifdef RB_PARAM_SHADOW_EN
            return m_shadow[a];
`else
            return m_cfg[a];
`endif
        end
        if (a >= 32 && a < 36) return m_stat[a-32];
        if (a >= 36 && a < 40) return m_mask[a-36];
        return 8'h00;
    endfunction

    function automatic logic [NC*8-1:0] m_cfg_img();
        logic [NC*8-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[i*8 +: 8] = m_cfg[i];
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        write_en = 1'b1;
        reg_en = 1'b1;
        address = 8'd5;
        data_write_in = 8'hFF;
        stat_set = '1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            m_cfg[i] = 8'hA5;
            m_shadow[i] = 8'hA5;
        end
        for (int k = 0; k < NS; k++) begin
            m_stat[k] = 8'h00;
            m_mask[k] = 8'h00;
        end
        chk("rst_rvalid", 128'(read_valid), 128'(0));
        chk("rst_rdata", 128'(data_read_out), 128'(0));
        chk("rst_cfg", 128'(cfg_out), 128'(RST_IMG));
        chk("rst_pulse", 128'(cfg_wr_pulse), 128'(0));
        chk("rst_irq", 128'(irq), 128'(0));
        reset = 1'b0;
        write_en = 1'b0;
        reg_en = 1'b0;
        stat_set = '0;
    endtask

    task automatic step(input logic wen, input logic ren,
                        input logic [7:0] adr, input logic [7:0] wd,
                        input logic [NS*8-1:0] ss);
        logic [7:0]    e_rd;
        logic          e_rv;
        logic          e_irq;
        logic [NC-1:0] e_pulse;
        int            a;
        a = int'(adr);
        write_en = wen;
        reg_en = ren;
        address = adr;
        data_write_in = wd;
        stat_set = ss;
        e_rv = ren;
        e_rd = ren ? m_read(a) : 8'h00;
        e_irq = 1'b0;
        for (int k = 0; k < NS; k++) e_irq |= |(m_stat[k] & m_mask[k]);
        e_pulse = '0;
        if (wen) begin
            if (a < NC) begin
`ifdef RB_PARAM_SHADOW_EN
                m_shadow[a] = wd;
`else
                m_cfg[a] = wd;
                e_pulse[a] = 1'b1;
`endif
            end else if (a >= 32 && a < 36) begin
                m_stat[a-32] = m_stat[a-32] & ~wd;
            end else if (a >= 36 && a < 40) begin
                m_mask[a-36] = wd;
            end
`ifdef RB_PARAM_SHADOW_EN
            else if (a == 255 && wd[0]) begin
                for (int i = 0; i < NC; i++) begin
                    if (m_shadow[i] != m_cfg[i]) e_pulse[i] = 1'b1;
                    m_cfg[i] = m_shadow[i];
                end
            end
`endif
        end
        for (int k = 0; k < NS; k++) m_stat[k] |= ss[k*8 +: 8];
        @(posedge clk);
        #1;
        chk("rvalid", 128'(read_valid), 128'(e_rv));
        chk("rdata", 128'(data_read_out), 128'(e_rd));
        chk("cfg_out", 128'(cfg_out), 128'(m_cfg_img()));
        chk("pulse", 128'(cfg_wr_pulse), 128'(e_pulse));
        chk("irq", 128'(irq), 128'(e_irq));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'd0, 8'd0, '0);
    endtask

    initial begin
        reset = 1'b0;
        address = 8'd0;
        data_write_in = 8'd0;
        write_en = 1'b0;
        reg_en = 1'b0;
        stat_set = '0;
        @(posedge clk);
        #1;
        do_reset();
        idle();
        chk("post_rst_irq", 128'(irq), 128'(0));

        // config write then read back
        step(1'b1, 1'b0, 8'd5, 8'h3C, '0);
`ifndef RB_PARAM_SHADOW_EN
        chk("cfg5", 128'(cfg_out[47:40]), 128'(8'h3C));
        chk("pulse5", 128'(cfg_wr_pulse), 128'(16'h0020));
`endif
        idle();
        chk("pulse5_off", 128'(cfg_wr_pulse), 128'(0));
        step(1'b0, 1'b1, 8'd5, 8'h00, '0);
        chk("rd5", 128'(data_read_out), 128'(8'h3C));
        idle();
        chk("rv_one_cycle", 128'(read_valid), 128'(0));

        // sticky status, mask, irq, W1C
        step(1'b0, 1'b0, 8'd0, 8'h00, 32'h0000_0081);
        step(1'b1, 1'b0, 8'd36, 8'h01, '0);
        idle();
        idle();
        chk("irq_on", 128'(irq), 128'(1));
        step(1'b1, 1'b0, 8'd32, 8'h01, '0);
        idle();
        idle();
        chk("irq_off", 128'(irq), 128'(0));
        step(1'b0, 1'b1, 8'd32, 8'h00, '0);
        chk("stat_80", 128'(data_read_out), 128'(8'h80));

        // set beats clear in the same cycle
        step(1'b1, 1'b0, 8'd32, 8'h01, 32'h0000_0001);
        step(1'b0, 1'b1, 8'd32, 8'h00, '0);
        chk("set_wins", 128'(data_read_out), 128'(8'h81));
        step(1'b0, 1'b1, 8'd200, 8'h00, '0);
        chk("unmapped_rd", 128'(data_read_out), 128'(0));
        chk("unmapped_rv", 128'(read_valid), 128'(1));
        step(1'b0, 1'b1, 8'd255, 8'h00, '0);

        // read-during-write returns the old value
        step(1'b1, 1'b1, 8'd5, 8'h77, '0);
`ifndef RB_PARAM_SHADOW_EN
        chk("rdw_old", 128'(data_read_out), 128'(8'h3C));
`endif

`ifdef RB_PARAM_SHADOW_EN
        do_reset();
        step(1'b1, 1'b0, 8'd2, 8'h11, '0);
        chk("shadow_hold", 128'(cfg_out[23:16]), 128'(8'hA5));
        step(1'b1, 1'b0, 8'hFF, 8'h01, '0);
        chk("commit_cfg2", 128'(cfg_out[23:16]), 128'(8'h11));
        chk("commit_pulse", 128'(cfg_wr_pulse), 128'(16'h0004));
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0]      ra;
            logic [NS*8-1:0] rs;
            case ($urandom_range(0, 4))
                0: ra = 8'($urandom_range(0, NC - 1));
                1: ra = 8'($urandom_range(32, 35));
                2: ra = 8'($urandom_range(36, 39));
                3: ra = 8'hFF;
                default: ra = 8'($urandom_range(0, 255));
            endcase
            rs = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) rs = '0;
            step(1'($urandom), 1'($urandom), ra, 8'($urandom), rs);
            if (n == 300) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
